// File: rtl/alu_postprocess_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : alu_postprocess_pkg                                    |
// | Desc    : Shared constants, opcodes and FIFO entry layout for    |
// |           the ALU output stage.                                  |
// | Rev     : 1.0 - initial release                                  |
// +------------------------------------------------------------------+
package alu_postprocess_pkg;

  // Datapath width; bit WIDTH-1 is the sign bit for every flag rule.
  localparam int WIDTH = 4;

  // Opcodes shared with the operand preprocessor.
  localparam logic [2:0] OP_PASS_A = 3'b000;
  localparam logic [2:0] OP_NEG_A  = 3'b001;
  localparam logic [2:0] OP_ADD    = 3'b010;
  localparam logic [2:0] OP_NOT_A  = 3'b100;

  // Result FIFO depth.
  localparam int DEPTH = 2;

  // One buffered result: {S, Z, N, C, V, Err}.
  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic             z;
    logic             n;
    logic             c;
    logic             v;
    logic             err;
  } entry_t;

  // Any opcode outside the four defined ones is reserved.
  function automatic logic is_reserved(input logic [2:0] op);
    return !((op == OP_PASS_A) || (op == OP_NEG_A) ||
             (op == OP_ADD)    || (op == OP_NOT_A));
  endfunction

  // Only the adder-based operations report carry and overflow.
  function automatic logic is_arith(input logic [2:0] op);
    return (op == OP_NEG_A) || (op == OP_ADD);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_postprocess_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : alu_postprocess_if                                     |
// | Desc    : Input and output handshake bundle of the ALU output    |
// |           stage.                                                 |
// | Rev     : 1.0 - initial release                                  |
// +------------------------------------------------------------------+
interface alu_postprocess_if;
  import alu_postprocess_pkg::*;

  // Producer side
  logic [WIDTH-1:0] R;
  logic             Cout;
  logic             AMsb;
  logic             BMsb;
  logic [2:0]       Op;
  logic             in_valid;
  logic             in_ready;

  // Consumer side
  logic [WIDTH-1:0] S;
  logic             Z;
  logic             N;
  logic             C;
  logic             V;
  logic             Err;
  logic             out_valid;
  logic             out_ready;

  // Environment that drives operands and consumes results.
  modport master (
    output R, Cout, AMsb, BMsb, Op, in_valid, out_ready,
    input  in_ready, S, Z, N, C, V, Err, out_valid
  );

  // The output stage itself.
  modport slave (
    input  R, Cout, AMsb, BMsb, Op, in_valid, out_ready,
    output in_ready, S, Z, N, C, V, Err, out_valid
  );

endinterface
`default_nettype wire

// File: rtl/alu_postprocess_flags.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : alu_flags                                              |
// | Desc    : Combinational result/flag generation for one adder     |
// |           result, producing a complete FIFO entry.               |
// | Rev     : 1.0 - initial release                                  |
// +------------------------------------------------------------------+
module alu_flags
  import alu_postprocess_pkg::*;
(
  input  logic [WIDTH-1:0] r_i,
  input  logic             cout_i,
  input  logic             amsb_i,
  input  logic             bmsb_i,
  input  logic [2:0]       op_i,
  output entry_t           entry_o
);

  // Reserved opcodes yield a zero result tagged with Err; valid opcodes
  // pass R through and derive carry/overflow only for adder operations.
  always_comb begin
    entry_o = '0;
    if (is_reserved(op_i)) begin
      entry_o.z   = 1'b1;
      entry_o.err = 1'b1;
    end else begin
      entry_o.s = r_i;
      entry_o.z = (r_i == '0);
      entry_o.n = r_i[WIDTH-1];
      if (is_arith(op_i)) begin
        entry_o.c = cout_i;
        entry_o.v = (amsb_i == bmsb_i) && (r_i[WIDTH-1] != amsb_i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_postprocess.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : alu_postprocess                                        |
// | Desc    : ALU output stage: flag generation, 2-entry result FIFO |
// |           behind valid/ready, sticky overflow with clear.        |
// | Rev     : 1.0 - initial release                                  |
// +------------------------------------------------------------------+
module alu_postprocess
  import alu_postprocess_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  alu_postprocess_if.slave  bus,
  input  logic              clr,
  output logic              ovf_sticky
);

  entry_t     wr_entry;
  entry_t     head;
  entry_t     mem_q [DEPTH];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;
  logic       sticky_q, sticky_d;
  logic       push;
  logic       pop;

  alu_flags u_flags (
    .r_i     (bus.R),
    .cout_i  (bus.Cout),
    .amsb_i  (bus.AMsb),
    .bmsb_i  (bus.BMsb),
    .op_i    (bus.Op),
    .entry_o (wr_entry)
  );

  // Ready/valid come straight from the count register, so neither side
  // sees a combinational path from the other.
  assign bus.in_ready  = (count_q != 2'(DEPTH));
  assign bus.out_valid = (count_q != 2'd0);
  assign push          = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;

  // Head of the FIFO; shows the last-read slot when empty.
  assign head    = mem_q[rd_ptr_q];
  assign bus.S   = head.s;
  assign bus.Z   = head.z;
  assign bus.N   = head.n;
  assign bus.C   = head.c;
  assign bus.V   = head.v;
  assign bus.Err = head.err;

  assign ovf_sticky = sticky_q;

  // Next-state for pointers, occupancy and the sticky overflow bit.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    sticky_d = sticky_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 2'd1;
    else if (pop && !push) count_d = count_q - 2'd1;
    // A new overflow beats a simultaneous clear so no event is lost.
    if (push && wr_entry.v) sticky_d = 1'b1;
    else if (clr)           sticky_d = 1'b0;
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      sticky_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      sticky_q <= sticky_d;
    end
  end

  // Entry storage, cleared on reset so the idle head reads as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_postprocess.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : tb_alu_postprocess                                     |
// | Desc    : Self-checking bench for the ALU output stage.          |
// | Rev     : 1.0 - initial release                                  |
// +------------------------------------------------------------------+
module tb_alu_postprocess;

  typedef struct {
    logic [3:0] s;
    logic       z, n, c, v, err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic clr;
  logic ovf_sticky;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t q[$];
  logic exp_sticky = 1'b0;

  alu_postprocess_if bus ();

  alu_postprocess dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .clr        (clr),
    .ovf_sticky (ovf_sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected entry from the opcode table, in plain arithmetic terms.
  function automatic exp_t model_entry(input logic [2:0] op, input logic [3:0] r,
                                       input logic cout, input logic am, input logic bm);
    exp_t e;
    e.s = 4'd0; e.z = 1'b1; e.n = 1'b0; e.c = 1'b0; e.v = 1'b0; e.err = 1'b1;
    if (op == 3'b000 || op == 3'b100 || op == 3'b001 || op == 3'b010) begin
      e.err = 1'b0;
      e.s   = r;
      e.z   = (r == 4'd0);
      e.n   = (r >= 4'd8);
      if (op == 3'b001 || op == 3'b010) begin
        e.c = cout;
        // Two operands of the same sign giving a result of the other sign.
        e.v = (am == bm) && ((r >= 4'd8) != am);
      end
    end
    return e;
  endfunction

  // Reference queue and sticky bit, advanced on every clock edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      exp_sticky = 1'b0;
    end else begin
      bit   do_push, do_pop;
      exp_t e;
      e       = model_entry(bus.Op, bus.R, bus.Cout, bus.AMsb, bus.BMsb);
      do_push = bus.in_valid && (q.size() < 2);
      do_pop  = bus.out_ready && (q.size() > 0);
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(e);
      if (do_push && e.v) exp_sticky = 1'b1;
      else if (clr)       exp_sticky = 1'b0;
    end
  end

  // Compare DUT against the reference every cycle, mid-period.
  always @(negedge clk) begin
    chk("out_valid", bus.out_valid, q.size() != 0);
    chk("in_ready",  bus.in_ready,  q.size() != 2);
    chk("ovf_sticky", ovf_sticky, exp_sticky);
    if (q.size() != 0) begin
      chk("head_S",   bus.S,   q[0].s);
      chk("head_Z",   bus.Z,   q[0].z);
      chk("head_N",   bus.N,   q[0].n);
      chk("head_C",   bus.C,   q[0].c);
      chk("head_V",   bus.V,   q[0].v);
      chk("head_Err", bus.Err, q[0].err);
    end
  end

  // Drive one cycle of inputs, then wait for the mid-period sample point.
  task automatic drive(input logic iv, input logic [2:0] op, input logic [3:0] r,
                       input logic cout, input logic am, input logic bm);
    bus.in_valid = iv;
    bus.Op       = op;
    bus.R        = r;
    bus.Cout     = cout;
    bus.AMsb     = am;
    bus.BMsb     = bm;
    @(negedge clk);
  endtask

  task automatic chk_head(input string tag, input logic [3:0] s, input logic z,
                          input logic n, input logic c, input logic v, input logic err);
    chk({tag, "_S"},   bus.S,   s);
    chk({tag, "_Z"},   bus.Z,   z);
    chk({tag, "_N"},   bus.N,   n);
    chk({tag, "_C"},   bus.C,   c);
    chk({tag, "_V"},   bus.V,   v);
    chk({tag, "_Err"}, bus.Err, err);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with arbitrary inputs applied.
    rst_n         = 1'b0;
    clr           = 1'b1;
    bus.out_ready = 1'b1;
    drive(1'b1, 3'b010, 4'b1000, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk_head("rst", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_sticky", ovf_sticky, 1'b0);
    rst_n = 1'b1;
    clr   = 1'b0;
    drive(1'b0, 3'b000, 4'd0, 1'b0, 1'b0, 1'b0);

    // ADD overflow: 0xxx + 0xxx giving 1000.
    drive(1'b1, 3'b010, 4'b1000, 1'b0, 1'b0, 1'b0);
    chk("add_valid", bus.out_valid, 1'b1);
    chk_head("add", 4'b1000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("add_sticky", ovf_sticky, 1'b1);

    // NEG_A of zero, then NEG_A of the most negative value.
    drive(1'b1, 3'b001, 4'b0000, 1'b1, 1'b1, 1'b0);
    chk_head("neg0", 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 3'b001, 4'b1000, 1'b0, 1'b0, 1'b0);
    chk_head("neg8", 4'b1000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

    // Reserved opcode and NOT_A.
    drive(1'b1, 3'b011, 4'b0101, 1'b1, 1'b0, 1'b0);
    chk_head("rsv", 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 3'b100, 4'b1010, 1'b1, 1'b0, 1'b0);
    chk_head("not", 4'b1010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 3'b000, 4'd0, 1'b0, 1'b0, 1'b0);
    chk("drain_empty", bus.out_valid, 1'b0);

    // Backpressure: third push refused while full.
    bus.out_ready = 1'b0;
    drive(1'b1, 3'b000, 4'b0001, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 3'b000, 4'b0010, 1'b0, 1'b0, 1'b0);
    chk("bp_full_ready", bus.in_ready, 1'b0);
    drive(1'b1, 3'b000, 4'b0011, 1'b0, 1'b0, 1'b0);
    chk("bp_still_full", bus.in_ready, 1'b0);
    chk("bp_head1", bus.S, 4'b0001);
    bus.out_ready = 1'b1;
    drive(1'b0, 3'b000, 4'd0, 1'b0, 1'b0, 1'b0);
    chk("bp_head2", bus.S, 4'b0010);
    chk("bp_ready_back", bus.in_ready, 1'b1);
    drive(1'b0, 3'b000, 4'd0, 1'b0, 1'b0, 1'b0);
    chk("bp_empty", bus.out_valid, 1'b0);

    // Sticky clear, then set-wins-over-clear collision.
    chk("stk_before", ovf_sticky, 1'b1);
    clr = 1'b1;
    drive(1'b0, 3'b000, 4'd0, 1'b0, 1'b0, 1'b0);
    chk("stk_cleared", ovf_sticky, 1'b0);
    drive(1'b1, 3'b010, 4'b1000, 1'b0, 1'b0, 1'b0);
    chk("stk_collide", ovf_sticky, 1'b1);
    clr = 1'b0;
    drive(1'b0, 3'b000, 4'd0, 1'b0, 1'b0, 1'b0);

    // Reset asserted with two entries buffered.
    bus.out_ready = 1'b0;
    drive(1'b1, 3'b000, 4'b0101, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 3'b000, 4'b0110, 1'b0, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    chk("pre_rst_full", bus.in_ready, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", bus.out_valid, 1'b0);
    chk("mid_rst_ready", bus.in_ready, 1'b1);
    chk("mid_rst_sticky", ovf_sticky, 1'b0);
    @(negedge clk);
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    drive(1'b1, 3'b000, 4'b0111, 1'b0, 1'b0, 1'b0);
    chk_head("post_rst", 4'b0111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("post_rst_valid", bus.out_valid, 1'b1);

    // Mixed traffic checked by the reference model.
    for (int i = 0; i < 40; i++) begin
      bus.out_ready = 1'($urandom_range(0, 3) != 0);
      clr           = 1'($urandom_range(0, 7) == 0);
      drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    clr = 1'b0;
    drive(1'b0, 3'b000, 4'd0, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_postprocess.md
# alu_postprocess

Output stage of the 4-bit ALU datapath; it sits downstream of the operand preprocessor and the adder. It takes the raw adder sum and carry with the opcode and operand sign bits, computes the result flags, and buffers each result in a 2-entry FIFO behind a valid/ready handshake. A sticky overflow bit accumulates over accepted results until software clears it.

## Interface
- WIDTH, 4, datapath width; all flag rules reference bit WIDTH-1 as the sign bit
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- R  in  WIDTH  raw adder sum of AMod+BMod(+carry-in)
- Cout  in  1  adder carry-out
- AMsb  in  1  sign bit of AMod fed to the adder
- BMsb  in  1  sign bit of BMod fed to the adder
- Op  in  3  opcode that produced R
- in_valid  in  1  R/Cout/AMsb/BMsb/Op are valid this cycle
- in_ready  out  1  stage can accept; equals (count != 2)
- S  out  WIDTH  result at FIFO head
- Z, N, C, V  out  1 each  zero, negative, carry, overflow flags of the head entry
- Err  out  1  head entry carried a reserved opcode
- out_valid  out  1  head entry present; equals (count != 0)
- out_ready  in  1  consumer takes head when high with out_valid
- clr  in  1  synchronous clear of ovf_sticky
- ovf_sticky  out  1  set by any accepted entry with V=1

## Operation
- Opcodes: 000 PASS_A, 001 NEG_A, 010 ADD, 100 NOT_A; every other value is reserved.
- Entry computed combinationally at accept time, from the inputs only:
  - S = R for valid opcodes; S = 0 for reserved opcodes.
  - Z = (S == 0). N = S[WIDTH-1].
  - C = Cout for NEG_A/ADD; 0 otherwise.
  - V = (AMsb == BMsb) && (R[WIDTH-1] != AMsb) for NEG_A/ADD; 0 otherwise.
  - Err = 1 only for reserved opcodes. Reserved entries also force Z=1, N=0, C=0, V=0.
- Push: in_valid && in_ready. Pop: out_valid && out_ready.
- FIFO: 2 entries with circular write/read pointers. The entry is {S, Z, N, C, V, Err}, which is 9 bits at WIDTH=4.
- count register holds 0..2:
  - push only: +1
  - pop only: −1
  - push and pop in the same cycle: unchanged
- Full (count=2): in_ready=0, so no push can occur. A pop in that cycle frees a slot, and in_ready rises on the next cycle (no combinational ready path from out_ready).
- Empty (count=0): out_valid=0, and S and the flags show the last-read slot (don't care). A push into an empty FIFO is not visible at the head until the next cycle (no bypass).
- Pointers wrap modulo 2.
- ovf_sticky next-state, in priority order:
  - push with V=1 → 1 (set wins over a simultaneous clr)
  - else clr → 0
  - else hold

## Timing
- Reset (async assert, output values immediate):
  - count=0, pointers=0, storage=0, ovf_sticky=0
  - hence in_ready=1, out_valid=0, S=0, Z=N=C=V=Err=0
- Latency: push at edge k → out_valid=1 with that entry at the head after edge k.
- Throughput: 1 entry/cycle sustained when out_ready is held high.
- Reset asserted mid-stream discards all buffered entries. The first push after deassertion behaves as a push into an empty FIFO.
- Inputs are sampled only on push cycles. Input values are ignored when in_valid=0 or in_ready=0.
- Outputs S, Z, N, C, V, Err, out_valid, in_ready and ovf_sticky are register- or count-derived; none depends combinationally on the data inputs.

## Structure
- Shared include alu_defs.vh holds:
  - opcode localparams OP_PASS_A, OP_NEG_A, OP_ADD, OP_NOT_A
  - entry field offsets
  - FIFO depth constant (2)
  - The operand preprocessor uses the same opcode constants.
- Sub-module alu_flags: combinational; (R, Cout, AMsb, BMsb, Op) → {S, Z, N, C, V, Err}. It is instantiated once, at the FIFO write port.
- Top level holds the FIFO storage, pointers, count, handshake and sticky logic.

## Test plan
- Reset: hold rst_n=0 with arbitrary inputs → in_ready=1, out_valid=0, all flags 0, ovf_sticky=0. Then release.
- ADD overflow: Op=010, R=1000, Cout=0, AMsb=0, BMsb=0, pushed; out_ready=1 → next cycle S=1000, N=1, V=1, C=0, Z=0, and ovf_sticky=1.
- NEG_A of zero: Op=001, R=0000, Cout=1, AMsb=1, BMsb=0 → S=0000, Z=1, C=1, V=0. Then NEG_A of 1000 (R=1000, AMsb=0, BMsb=0, Cout=0) → V=1.
- Reserved/passive ops:
  - Op=011, R=0101 → S=0000, Err=1, Z=1, C=V=0.
  - Op=100, R=1010, Cout=1 → C=0, N=1, Err=0.
- Backpressure: out_ready=0, push 3 entries (0001, 0010, 0011) on consecutive cycles → the third is refused (in_ready=0 after two). Raise out_ready → 0001 then 0010 pop in order, and in_ready=1 the cycle after the first pop.
- Sticky/clr collision: ovf_sticky=1, clr=1 with no push → clears next cycle. Then clr=1 in the same cycle as a push with V=1 → ovf_sticky=1. Finally, assert rst_n=0 with 2 entries buffered → out_valid=0 immediately.
